alu_regfile_pipe: RTL and testbench
===================================

Name: alu_regfile_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational register-file-plus-ALU datapath.
- Issue stage reads two operands, or one operand plus an immediate, from a 2**ADDR_W x DATA_W register file and registers them into an execute stage.
- Execute stage implements the 16 ARM data-processing opcodes, writes back, and holds an NZCV flag register with conditional update.
- Forwarding lets dependent operations issue back-to-back; throughput is one op per cycle. Sits in the core between decode and the future shifter/memory stages.

Parameters:
DATA_W, 32, datapath and register width (>=8)
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low; registers and state clear on a rising clock edge while reset==0
in_valid  in  1  op presented this cycle; sampled each rising edge
op  in  4  ARM opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN
set_flags  in  1  S bit; update NZCV
rn  in  ADDR_W  operand-1 register
rm  in  ADDR_W  operand-2 register (ignored when use_imm)
rd  in  ADDR_W  destination register
use_imm  in  1  operand 2 = imm
imm  in  DATA_W  immediate operand
result  out  DATA_W  registered ALU result
result_valid  out  1  one-cycle pulse per completed op
result_rd  out  ADDR_W  destination of result
result_we  out  1  result was written to the register file
flags  out  4  registered {N,Z,C,V}
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  combinational read of regfile[dbg_addr]; not forwarded

Behaviour:
- Reset (reset==0 at an edge):
  - all registers 0; flags 0; result 0; result_valid 0; result_we 0; result_rd 0.
  - the execute-stage valid bit clears, so an in-flight op is dropped with no writeback and no flag change.
  - in_valid is ignored while reset==0.
- Issue, edge E0 with in_valid==1:
  - capture op, set_flags, rd, op1 = R[rn], op2 = use_imm ? imm : R[rm] into the execute register; set ex_valid.
- Execute:
  - the ALU is combinational from the execute register.
  - at edge E1: result <= alu_out, result_rd <= rd, result_valid <= 1, result_we <= (op not in 8..B).
  - when result_we, R[rd] <= alu_out at E1. Latency: issue edge to visible result is 1 cycle.
- No op in execute at an edge: result_valid <= 0 and result_we <= 0; result and flags hold.
- Forwarding:
  - when ex_valid and the execute op writes back and ex_rd == rn (or rm), the issuing op takes alu_out instead of the stale regfile value.
  - both operands forward independently. No stalls ever.
- Arithmetic is modulo 2**DATA_W.
  - ADD/CMN/ADC: C = carry out of bit DATA_W-1.
  - SUB/RSB/SBC/RSC/CMP: C = NOT borrow. SBC = op1 - op2 - !C; RSC = op2 - op1 - !C; ADC adds C.
  - V = signed overflow, computed for arithmetic ops only.
  - Carry-in is the flag register value at the execute cycle, which already includes any update from the immediately preceding op.
- Flag update, at E1 when set_flags==1 or op in 8..B:
  - N = result[DATA_W-1]; Z = (result == 0).
  - arithmetic ops also update C and V.
  - logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) leave C and V unchanged.
  - if neither condition holds, flags hold.
- MOV/MVN ignore op1.
- Same-register cases:
  - rd == rn == rm is legal.
  - a regfile write and an issue read of the same address at the same edge resolve via forwarding.
  - dbg_data shows the old value until the edge completes.

Test Plan:
- Reset: hold reset=0 for 2 edges after random traffic -> all regs 0 via dbg_data, flags=0000, result_valid=0; an op issued on the last reset edge produces no result_valid.
- Back-to-back forwarding: MOV r1,#5; MOV r2,#7; ADD r3,r1,r2 on consecutive cycles -> results 5, 7, 12 on consecutive cycles; dbg r3=12.
- Subtract flags: r1=5, r2=7, SUBS r4,r1,r2 -> result 0xFFFFFFFE, flags N=1 Z=0 C=0 V=0. CMP r2,r1 -> flags 0010, result_we=0, r4 unchanged.
- Overflow and carry chain:
  - MOV r5,#0x7FFFFFFF; ADDS r6,r5,#1 -> 0x80000000, NZCV=1001.
  - MVN r7,#0; ADDS r8,r7,#1 -> 0, NZCV=0110.
  - next ADC r9,r8,#0 -> 1 (uses the C just set).
- Logical preserves C/V: after NZCV=0110, ANDS r1,r1,#0 -> NZCV=0110; ORRS with 0x80000000 -> NZCV=1010.
- Reset mid-op: issue ADD r3,... then assert reset at the next edge -> no result_valid, r3=0, flags 0000.

Source files
------------

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: two-stage register file + ARM data-processing ALU.
// Issue stage reads operands (with forwarding from execute) into the
// execute register; execute stage computes, writes back and updates NZCV.
module alu_regfile_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        op,
  input  logic              set_flags,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [ADDR_W-1:0] rd,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [ADDR_W-1:0] result_rd,
  output logic              result_we,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              ex_valid;
  logic [3:0]        ex_op;
  logic              ex_set_flags;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;

  logic              ex_we;
  logic              fwd_en;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;

  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W:0]   sum;
  logic              is_arith;
  logic              alu_c;
  logic              alu_v;
  logic              flag_upd;

  // TST/TEQ/CMP/CMN (8..B) only set flags and never write back
  assign ex_we  = (ex_op[3:2] != 2'b10);
  assign fwd_en = ex_valid && ex_we;

  // Operand selection with bypass of the value being written this edge
  assign issue_op1 = (fwd_en && (ex_rd == rn)) ? alu_out : regs[rn];
  assign issue_op2 = use_imm ? imm :
                     ((fwd_en && (ex_rd == rm)) ? alu_out : regs[rm]);

  assign dbg_data = regs[dbg_addr];

  // ALU: subtraction forms are a + ~b + cin so carry out is NOT borrow
  always_comb begin
    add_a    = ex_op1;
    add_b    = ex_op2;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    alu_out  = '0;
    sum      = '0;
    case (ex_op)
      4'h0, 4'h8: alu_out = ex_op1 & ex_op2;
      4'h1, 4'h9: alu_out = ex_op1 ^ ex_op2;
      4'h2, 4'hA: begin add_b = ~ex_op2; add_cin = 1'b1; is_arith = 1'b1; end
      4'h3:       begin add_a = ex_op2; add_b = ~ex_op1; add_cin = 1'b1; is_arith = 1'b1; end
      4'h4, 4'hB: is_arith = 1'b1;
      4'h5:       begin add_cin = flags[1]; is_arith = 1'b1; end
      4'h6:       begin add_b = ~ex_op2; add_cin = flags[1]; is_arith = 1'b1; end
      4'h7:       begin add_a = ex_op2; add_b = ~ex_op1; add_cin = flags[1]; is_arith = 1'b1; end
      4'hC:       alu_out = ex_op1 | ex_op2;
      4'hD:       alu_out = ex_op2;
      4'hE:       alu_out = ex_op1 & ~ex_op2;
      default:    alu_out = ~ex_op2;
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    if (is_arith) alu_out = sum[MSB:0];
  end

  assign alu_c    = sum[DATA_W];
  assign alu_v    = (add_a[MSB] == add_b[MSB]) && (sum[MSB] != add_a[MSB]);
  assign flag_upd = ex_set_flags || !ex_we;

  // Issue stage: capture operands into the execute register
  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_op        <= '0;
      ex_set_flags <= 1'b0;
      ex_rd        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
    end else begin
      ex_valid <= in_valid;
      if (in_valid) begin
        ex_op        <= op;
        ex_set_flags <= set_flags;
        ex_rd        <= rd;
        ex_op1       <= issue_op1;
        ex_op2       <= issue_op2;
      end
    end
  end

  // Execute stage: register the result and update NZCV
  always_ff @(posedge clock) begin
    if (!reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_rd    <= '0;
      result_we    <= 1'b0;
      flags        <= 4'b0000;
    end else if (ex_valid) begin
      result       <= alu_out;
      result_valid <= 1'b1;
      result_rd    <= ex_rd;
      result_we    <= ex_we;
      if (flag_upd) begin
        flags[3] <= alu_out[MSB];
        flags[2] <= (alu_out == '0);
        if (is_arith) begin
          flags[1] <= alu_c;
          flags[0] <= alu_v;
        end
      end
    end else begin
      result_valid <= 1'b0;
      result_we    <= 1'b0;
    end
  end

  // Register file write-back
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (ex_valid && ex_we) begin
      regs[ex_rd] <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb_alu_regfile_pipe: directed vectors with hand-computed results and flags.
module tb_alu_regfile_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [3:0]  op;
  logic        set_flags;
  logic [3:0]  rn, rm, rd;
  logic        use_imm;
  logic [31:0] imm;
  logic [31:0] result;
  logic        result_valid;
  logic [3:0]  result_rd;
  logic        result_we;
  logic [3:0]  flags;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_regfile_pipe #(.DATA_W(32), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op),
    .set_flags(set_flags), .rn(rn), .rm(rm), .rd(rd), .use_imm(use_imm),
    .imm(imm), .result(result), .result_valid(result_valid),
    .result_rd(result_rd), .result_we(result_we), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the bench always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one op for the upcoming rising edge (call at a falling edge)
  task automatic issue_op(input logic [3:0] o, input logic s, input logic [3:0] n,
                          input logic [3:0] m, input logic [3:0] d,
                          input logic ui, input logic [31:0] im);
    in_valid  = 1'b1;
    op        = o;
    set_flags = s;
    rn        = n;
    rm        = m;
    rd        = d;
    use_imm   = ui;
    imm       = im;
  endtask

  // Run one isolated op; returns at the falling edge where its result is visible
  task automatic apply_stimulus(input logic [3:0] o, input logic s, input logic [3:0] n,
                                input logic [3:0] m, input logic [3:0] d,
                                input logic ui, input logic [31:0] im);
    @(negedge clock);
    issue_op(o, s, n, m, d, ui, im);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_res(input string tag, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    check_output({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    check_output({tag, "_res"}, result, exp_res);
    check_output({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_flags});
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check_output(tag, dbg_data, exp);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; op = '0; set_flags = 1'b0;
    rn = '0; rm = '0; rd = '0; use_imm = 1'b0; imm = '0; dbg_addr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Random traffic before the reset check
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      issue_op((i % 2) ? 4'h4 : 4'hD, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)),
               4'($urandom_range(15)), (i % 2) == 0, $urandom);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue_op(4'h4, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 32'd9);
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    check_output("rst_valid", {31'd0, result_valid}, 32'd0);
    check_output("rst_we", {31'd0, result_we}, 32'd0);
    check_output("rst_result", result, 32'd0);
    check_output("rst_flags", {28'd0, flags}, 32'd0);
    for (int i = 0; i < 16; i++) check_reg($sformatf("rst_r%0d", i), 4'(i), 32'd0);
    @(negedge clock);
    check_output("rst_edge_op_dropped", {31'd0, result_valid}, 32'd0);

    // Back-to-back with forwarding
    @(negedge clock); issue_op(4'hD, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 32'd5);
    @(negedge clock); issue_op(4'hD, 1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 32'd7);
    @(negedge clock); issue_op(4'h4, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
    check_res("b2b_mov5", 32'd5, 4'h0);
    @(negedge clock); in_valid = 1'b0;
    check_res("b2b_mov7", 32'd7, 4'h0);
    @(negedge clock);
    check_res("b2b_add", 32'd12, 4'h0);
    check_output("b2b_rd", {28'd0, result_rd}, 32'd3);
    check_reg("b2b_r3", 4'd3, 32'd12);

    // Subtract flags and compare without write-back
    apply_stimulus(4'h2, 1'b1, 4'd1, 4'd2, 4'd4, 1'b0, 32'd0);
    check_res("subs", 32'hFFFF_FFFE, 4'b1000);
    check_output("subs_we", {31'd0, result_we}, 32'd1);
    apply_stimulus(4'hA, 1'b0, 4'd2, 4'd1, 4'd4, 1'b0, 32'd0);
    check_res("cmp", 32'd2, 4'b0010);
    check_output("cmp_we", {31'd0, result_we}, 32'd0);
    check_reg("cmp_r4", 4'd4, 32'hFFFF_FFFE);

    // Overflow and carry chain
    apply_stimulus(4'hD, 1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 32'h7FFF_FFFF);
    apply_stimulus(4'h4, 1'b1, 4'd5, 4'd0, 4'd6, 1'b1, 32'd1);
    check_res("adds_ovf", 32'h8000_0000, 4'b1001);
    apply_stimulus(4'hF, 1'b0, 4'd0, 4'd0, 4'd7, 1'b1, 32'd0);
    check_res("mvn_hold", 32'hFFFF_FFFF, 4'b1001);
    @(negedge clock); issue_op(4'h4, 1'b1, 4'd7, 4'd0, 4'd8, 1'b1, 32'd1);
    @(negedge clock); issue_op(4'h5, 1'b0, 4'd8, 4'd0, 4'd9, 1'b1, 32'd0);
    @(negedge clock); in_valid = 1'b0;
    check_res("adds_carry", 32'd0, 4'b0110);
    @(negedge clock);
    check_res("adc_chain", 32'd1, 4'b0110);
    check_reg("adc_r9", 4'd9, 32'd1);

    // Logical ops keep C and V
    apply_stimulus(4'h0, 1'b1, 4'd1, 4'd0, 4'd1, 1'b1, 32'd0);
    check_res("ands", 32'd0, 4'b0110);
    apply_stimulus(4'hC, 1'b1, 4'd1, 4'd0, 4'd10, 1'b1, 32'h8000_0000);
    check_res("orrs", 32'h8000_0000, 4'b1010);

    // Reset while an op is in execute
    @(negedge clock); issue_op(4'h4, 1'b1, 4'd3, 4'd0, 4'd3, 1'b1, 32'd1);
    @(negedge clock); reset = 1'b0; in_valid = 1'b0;
    @(negedge clock); reset = 1'b1;
    check_output("midrst_valid", {31'd0, result_valid}, 32'd0);
    check_output("midrst_flags", {28'd0, flags}, 32'd0);
    check_reg("midrst_r3", 4'd3, 32'd0);
    @(negedge clock);
    check_output("midrst_valid2", {31'd0, result_valid}, 32'd0);
    check_reg("midrst_r3b", 4'd3, 32'd0);

    // Remaining opcodes with carry-in and borrow cases
    apply_stimulus(4'hD, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 32'd3);
    apply_stimulus(4'h3, 1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 32'd10);
    check_res("rsbs", 32'd7, 4'b0010);
    apply_stimulus(4'h6, 1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 32'd1);
    check_res("sbcs_c1", 32'd2, 4'b0010);
    apply_stimulus(4'h2, 1'b1, 4'd1, 4'd0, 4'd4, 1'b1, 32'd5);
    check_res("subs_borrow", 32'hFFFF_FFFE, 4'b1000);
    apply_stimulus(4'h6, 1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 32'd1);
    check_res("sbcs_c0", 32'd1, 4'b0010);
    apply_stimulus(4'h7, 1'b1, 4'd1, 4'd0, 4'd6, 1'b1, 32'd2);
    check_res("rscs", 32'hFFFF_FFFF, 4'b1000);
    apply_stimulus(4'h1, 1'b0, 4'd1, 4'd0, 4'd7, 1'b1, 32'hF);
    check_res("eor", 32'hC, 4'b1000);
    apply_stimulus(4'hE, 1'b0, 4'd1, 4'd0, 4'd8, 1'b1, 32'd1);
    check_res("bic", 32'd2, 4'b1000);
    apply_stimulus(4'h9, 1'b0, 4'd1, 4'd0, 4'd9, 1'b1, 32'd3);
    check_res("teq", 32'd0, 4'b0100);
    check_output("teq_we", {31'd0, result_we}, 32'd0);
    apply_stimulus(4'hB, 1'b0, 4'd1, 4'd0, 4'd9, 1'b1, 32'hFFFF_FFFD);
    check_res("cmn", 32'd0, 4'b0110);
    apply_stimulus(4'hD, 1'b0, 4'd0, 4'd0, 4'd10, 1'b1, 32'h8000_0000);
    apply_stimulus(4'h2, 1'b1, 4'd10, 4'd0, 4'd11, 1'b1, 32'd1);
    check_res("subs_ovf", 32'h7FFF_FFFF, 4'b0011);

    // rd == rn == rm with both operands forwarded
    @(negedge clock); issue_op(4'hD, 1'b0, 4'd0, 4'd0, 4'd12, 1'b1, 32'd3);
    @(negedge clock); issue_op(4'h4, 1'b0, 4'd12, 4'd12, 4'd12, 1'b0, 32'd0);
    @(negedge clock); issue_op(4'h4, 1'b0, 4'd12, 4'd12, 4'd12, 1'b0, 32'd0);
    check_output("same_mov", result, 32'd3);
    @(negedge clock); in_valid = 1'b0;
    check_output("same_add1", result, 32'd6);
    @(negedge clock);
    check_output("same_add2", result, 32'd12);
    check_reg("same_r12", 4'd12, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
